// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute control unit: computes next values for
// an external register bank (PC/IR/ACC/MDR/MAR/zflag) and drives a single
// port memory request. Ports: clk, rst (async, active low), *_reg current
// register values, *_next next register values, mem_req/mem_we/mem_addr/
// mem_wdata/mem_rdata/mem_ready memory handshake, halted status.
module control_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] PC_reg,
    input  logic [DATA_W-1:0] IR_reg,
    input  logic [DATA_W-1:0] ACC_reg,
    input  logic [DATA_W-1:0] MDR_reg,
    input  logic [ADDR_W-1:0] MAR_reg,
    input  logic              zflag_reg,
    output logic [ADDR_W-1:0] PC_next,
    output logic [DATA_W-1:0] IR_next,
    output logic [DATA_W-1:0] ACC_next,
    output logic [DATA_W-1:0] MDR_next,
    output logic [ADDR_W-1:0] MAR_next,
    output logic              zflag_next,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              halted
);

    typedef enum logic [2:0] {
        FETCH1, FETCH2, FETCH3, DECODE,
        EXEC_RD, EXEC_ALU, EXEC_WR, HALT
    } state_t;

    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_JMP   = 4'h6;
    localparam logic [3:0] OP_JZ    = 4'h7;
    localparam logic [3:0] OP_HALT  = 4'hF;

    state_t            state;
    state_t            state_nx;
    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic [DATA_W-1:0] acc_res;

    assign opcode    = IR_reg[DATA_W-1 -: 4];
    assign operand   = IR_reg[ADDR_W-1:0];
    assign mem_addr  = MAR_reg;
    assign mem_wdata = ACC_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FETCH1;
        else      state <= state_nx;
    end

    // ALU result; only consumed in EXEC_ALU, where opcode is an ALU op
    always_comb begin
        acc_res = ACC_reg;
        case (opcode)
            OP_LOAD: acc_res = MDR_reg;
            OP_ADD:  acc_res = ACC_reg + MDR_reg;
            OP_SUB:  acc_res = ACC_reg - MDR_reg;
            OP_AND:  acc_res = ACC_reg & MDR_reg;
            default: acc_res = ACC_reg;
        endcase
    end

    always_comb begin
        state_nx   = state;
        PC_next    = PC_reg;
        IR_next    = IR_reg;
        ACC_next   = ACC_reg;
        MDR_next   = MDR_reg;
        MAR_next   = MAR_reg;
        zflag_next = zflag_reg;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        halted     = 1'b0;
        // While reset is asserted everything holds and no request is made
        if (rst) begin
            case (state)
                FETCH1: begin
                    MAR_next = PC_reg;
                    state_nx = FETCH2;
                end
                FETCH2: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        MDR_next = mem_rdata;
                        state_nx = FETCH3;
                    end
                end
                FETCH3: begin
                    IR_next  = MDR_reg;
                    PC_next  = PC_reg + ADDR_W'(1);
                    state_nx = DECODE;
                end
                DECODE: begin
                    MAR_next = operand;
                    case (opcode)
                        OP_JMP: begin
                            PC_next  = operand;
                            state_nx = FETCH1;
                        end
                        OP_JZ: begin
                            if (zflag_reg) PC_next = operand;
                            state_nx = FETCH1;
                        end
                        OP_LOAD, OP_ADD,
                        OP_SUB, OP_AND: state_nx = EXEC_RD;
                        OP_STORE:       state_nx = EXEC_WR;
                        OP_HALT:        state_nx = HALT;
                        default:        state_nx = FETCH1;
                    endcase
                end
                EXEC_RD: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        MDR_next = mem_rdata;
                        state_nx = EXEC_ALU;
                    end
                end
                EXEC_ALU: begin
                    ACC_next   = acc_res;
                    zflag_next = (acc_res == '0);
                    state_nx   = FETCH1;
                end
                EXEC_WR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    if (mem_ready) state_nx = FETCH1;
                end
                HALT: begin
                    halted = 1'b1;
                end
                default: state_nx = FETCH1;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: register bank and memory model around the
// DUT, a table of single-instruction ALU vectors and directed sequences.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  pc, mar, pc_n, mar_n, mem_addr;
    logic [15:0] ir, acc, mdr, ir_n, acc_n, mdr_n;
    logic [15:0] mem_wdata, mem_rdata;
    logic        zf, zf_n, mem_req, mem_we, mem_ready, halted;

    logic [7:0]  p_pc = '0;
    logic [15:0] p_acc = '0;
    logic        p_zf = 1'b0;
    logic [15:0] mem [256];

    int          wr_cnt = 0;
    logic [7:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    int          checks = 0;
    int          failures = 0;

    control_sequencer dut (
        .clk(clk), .rst(rst),
        .PC_reg(pc), .IR_reg(ir), .ACC_reg(acc),
        .MDR_reg(mdr), .MAR_reg(mar), .zflag_reg(zf),
        .PC_next(pc_n), .IR_next(ir_n), .ACC_next(acc_n),
        .MDR_next(mdr_n), .MAR_next(mar_n), .zflag_next(zf_n),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .halted(halted)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    // Register bank: reset loads the bench's preset values
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= p_pc; ir <= '0; acc <= p_acc;
            mdr <= '0; mar <= '0; zf <= p_zf;
        end else begin
            pc <= pc_n; ir <= ir_n; acc <= acc_n;
            mdr <= mdr_n; mar <= mar_n; zf <= zf_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && mem_req && mem_we && mem_ready) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= mem_addr;
            wr_data <= mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    // Reset with presets applied; returns #1 after release in FETCH1
    task automatic do_reset(input logic [7:0] pc0, input logic [15:0] acc0,
                            input logic z0);
        p_pc = pc0; p_acc = acc0; p_zf = z0;
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        #1;
    endtask

    typedef struct {
        logic [15:0] instr;
        logic [15:0] opval;
        logic [15:0] acc0;
        logic        z0;
        logic [15:0] exp_acc;
        logic        exp_z;
    } alu_vec_t;

    alu_vec_t vecs [8];

    initial begin
        int n;
        vecs[0] = '{16'h1050, 16'h0000, 16'h1234, 1'b0, 16'h0000, 1'b1};
        vecs[1] = '{16'h1050, 16'h8001, 16'h0000, 1'b1, 16'h8001, 1'b0};
        vecs[2] = '{16'h3050, 16'h0F0F, 16'h1234, 1'b1, 16'h2143, 1'b0};
        vecs[3] = '{16'h3050, 16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1};
        vecs[4] = '{16'h4050, 16'h0001, 16'h0000, 1'b1, 16'hFFFF, 1'b0};
        vecs[5] = '{16'h4050, 16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b1};
        vecs[6] = '{16'h5050, 16'h0FF0, 16'hF0F0, 1'b1, 16'h00F0, 1'b0};
        vecs[7] = '{16'h5050, 16'h0F0F, 16'hF0F0, 1'b0, 16'h0000, 1'b1};

        mem_ready = 1'b1;
        clear_mem();

        // Reset state and first fetch cycles
        p_pc = 8'h00; p_acc = '0; p_zf = 1'b0;
        rst = 1'b0;
        step(1);
        chk("rst_req", {31'd0, mem_req}, 0);
        chk("rst_halted", {31'd0, halted}, 0);
        chk("rst_pc_hold", {24'd0, pc_n}, {24'd0, pc});
        rst = 1'b1;
        #1;
        chk("f1_mar", {24'd0, mar_n}, 32'h00);
        chk("f1_req", {31'd0, mem_req}, 0);
        step(1);
        chk("f2_req", {30'd0, mem_req, mem_we}, 32'h2);
        chk("f2_addr", {24'd0, mem_addr}, {24'd0, mar});

        // Zero-wait program
        clear_mem();
        mem[0] = 16'h1010; mem[1] = 16'h3011;
        mem[2] = 16'h2012; mem[3] = 16'hF000;
        mem[8'h10] = 16'h0005; mem[8'h11] = 16'hFFFB;
        do_reset(8'h00, 16'h0000, 1'b0);
        n = wr_cnt;
        step(6);
        chk("prog_acc_load", {16'd0, acc}, 32'h0005);
        step(6);
        chk("prog_acc_add", {16'd0, acc}, 32'h0000);
        chk("prog_z_add", {31'd0, zf}, 1);
        step(5);
        chk("prog_wr_cnt", wr_cnt - n, 1);
        chk("prog_wr_addr", {24'd0, wr_addr}, 32'h12);
        chk("prog_wr_data", {16'd0, wr_data}, 32'h0000);
        step(4);
        chk("prog_halted21", {31'd0, halted}, 1);
        step(2);
        chk("halt_stays", {30'd0, halted, mem_req}, 32'h2);

        // Cycle count to HALT measured independently, bounded
        do_reset(8'h00, 16'h0000, 1'b0);
        n = 0;
        while (!halted && n < 40) begin
            step(1);
            n++;
        end
        chk("prog_cycles", n, 21);

        // Table of single ALU instructions
        foreach (vecs[i]) begin
            clear_mem();
            mem[0] = vecs[i].instr;
            mem[8'h50] = vecs[i].opval;
            do_reset(8'h00, vecs[i].acc0, vecs[i].z0);
            step(6);
            chk($sformatf("alu%0d_acc", i), {16'd0, acc},
                {16'd0, vecs[i].exp_acc});
            chk($sformatf("alu%0d_z", i), {31'd0, zf},
                {31'd0, vecs[i].exp_z});
            chk($sformatf("alu%0d_f1", i), {23'd0, mem_req, mar_n},
                {24'd0, 8'h01});
        end

        // JZ taken
        clear_mem();
        mem[0] = 16'h7040;
        do_reset(8'h00, 16'h0000, 1'b1);
        step(3);
        chk("jz1_pc_next", {24'd0, pc_n}, 32'h40);
        chk("jz1_mar_next", {24'd0, mar_n}, 32'h40);
        step(1);
        chk("jz1_f1", {23'd0, mem_req, mar_n}, 32'h40);

        // JZ not taken
        do_reset(8'h00, 16'h0000, 1'b0);
        step(3);
        chk("jz0_pc_next", {24'd0, pc_n}, 32'h01);
        step(1);
        chk("jz0_f1", {23'd0, mem_req, mar_n}, 32'h01);
        step(1);
        chk("jz0_f2", {30'd0, mem_req, mem_we}, 32'h2);

        // JMP
        mem[0] = 16'h6077;
        do_reset(8'h00, 16'h0000, 1'b0);
        step(4);
        chk("jmp_pc", {24'd0, pc}, 32'h77);

        // Wait states during EXEC_RD
        clear_mem();
        mem[0] = 16'h1020; mem[8'h20] = 16'h1234;
        do_reset(8'h00, 16'h0000, 1'b0);
        step(4);
        mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("wait%0d_req", i), {30'd0, mem_req, mem_we},
                32'h2);
            chk($sformatf("wait%0d_addr", i), {24'd0, mem_addr}, 32'h20);
            chk($sformatf("wait%0d_mdr", i), {16'd0, mdr_n}, 32'h1020);
            step(1);
        end
        mem_ready = 1'b1;
        #1;
        chk("wait_rdy_req", {30'd0, mem_req, mem_we}, 32'h2);
        chk("wait_rdy_mdr", {16'd0, mdr_n}, 32'h1234);
        step(1);
        chk("wait_alu_acc", {16'd0, acc_n}, 32'h1234);

        // PC wrap in FETCH3
        clear_mem();
        do_reset(8'hFF, 16'h0000, 1'b0);
        step(2);
        chk("pc_wrap", {24'd0, pc_n}, 32'h00);

        // Reset during a stalled EXEC_WR
        clear_mem();
        mem[0] = 16'h2030;
        do_reset(8'h00, 16'hABCD, 1'b0);
        step(4);
        mem_ready = 1'b0;
        #1;
        chk("wr_req", {30'd0, mem_req, mem_we}, 32'h3);
        chk("wr_data", {8'd0, mem_addr, mem_wdata}, 32'h30ABCD);
        p_pc = 8'h00; p_acc = '0; p_zf = 1'b0;
        rst = 1'b0;
        #1;
        chk("wr_rst_req", {30'd0, mem_req, halted}, 0);
        step(1);
        rst = 1'b1;
        #1;
        chk("wr_rel_f1", {22'd0, halted, mem_req, mar_n}, 32'h00);
        mem_ready = 1'b1;
        step(1);
        chk("wr_rel_f2", {30'd0, mem_req, mem_we}, 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
